// File: rtl/ahb_slave_mem_responder.sv
// Memory-backed slave responder: latches a request, inserts programmable wait
// states, then returns a one-cycle ready with read data or an error response.
module ahb_slave_mem_responder #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    PRIV_WORDS = 16,
   parameter int                    WAIT_W     = 4,
   parameter int                    CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sel,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic                    write,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] strb,
   input  logic [3:0]              prot,
   input  logic                    other_error,
   input  logic [WAIT_W-1:0]       wait_cfg,
   output logic                    ready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic                    slave_error,
   output logic                    busy,
   output logic [CNT_W-1:0]        err_count
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  write_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [BYTES-1:0]      strb_q;
   logic [3:0]            prot_q;
   logic [WAIT_W-1:0]     cnt;
   logic                  inj;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] off;
   logic [ADDR_WIDTH-1:0] word_off;
   logic [IDX_W-1:0]      idx;
   logic                  out_of_range;
   logic                  misaligned;
   logic                  priv_viol;
   logic                  err_now;
   logic                  accept;
   logic                  commit;
   logic                  unused_prot;

   assign unused_prot = ^{prot_q[3:2], prot_q[0]};

   // Subtraction wraps addresses below BASE_ADDR into the out-of-range region.
   assign off          = addr_q - BASE_ADDR;
   assign word_off     = off >> OFF_W;
   assign idx          = IDX_W'(word_off);
   assign out_of_range = (off >> (OFF_W + IDX_W)) != '0;
   assign misaligned   = (off & ADDR_WIDTH'(BYTES - 1)) != '0;
   assign priv_viol    = (word_off < ADDR_WIDTH'(PRIV_WORDS)) && !prot_q[1];
   assign err_now      = inj | other_error | out_of_range | misaligned | priv_viol;

   assign accept = (state == ST_IDLE) && sel;
   assign commit = (state == ST_RESP) && write_q && !err_now;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (sel) state_nxt = (wait_cfg != '0) ? ST_WAIT : ST_RESP;
         ST_WAIT: if (cnt == WAIT_W'(1)) state_nxt = ST_RESP;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
         prot_q  <= '0;
         cnt     <= '0;
         inj     <= 1'b0;
      end else if (accept) begin
         addr_q  <= addr;
         write_q <= write;
         wdata_q <= wdata;
         strb_q  <= strb;
         prot_q  <= prot;
         cnt     <= wait_cfg;
         inj     <= other_error;
      end else if (state == ST_WAIT) begin
         cnt <= cnt - WAIT_W'(1);
         inj <= inj | other_error;
      end else if (state == ST_RESP) begin
         inj <= inj | other_error;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= '0;
      end else if ((state == ST_RESP) && err_now && (err_count != '1)) begin
         err_count <= err_count + CNT_W'(1);
      end
   end

   // Storage is deliberately not reset; a reset mid-transfer blocks commit.
   always_ff @(posedge clk) begin
      if (!rst && commit) begin
         for (int i = 0; i < BYTES; i++) begin
            if (strb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   assign ready       = (state == ST_RESP);
   assign busy        = (state != ST_IDLE);
   assign slave_error = ready && err_now;
   assign rdata       = (ready && !err_now && !write_q) ? mem[idx] : '0;

endmodule

// File: tb/tb_ahb_slave_mem_responder.sv
// Directed bench for ahb_slave_mem_responder: latency, byte strobes, error
// decode, injection, back-to-back transfers, counter saturation and reset abort.
module tb_ahb_slave_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic [31:0] addr;
   logic        write;
   logic [31:0] wdata;
   logic [3:0]  strb;
   logic [3:0]  prot;
   logic        other_error;
   logic [3:0]  wait_cfg;
   logic        ready;
   logic [31:0] rdata;
   logic        slave_error;
   logic        busy;
   logic [2:0]  err_count;

   int tests  = 0;
   int failed = 0;

   ahb_slave_mem_responder #(.CNT_W(3)) dut (
      .clk(clk), .rst(rst), .sel(sel), .addr(addr), .write(write),
      .wdata(wdata), .strb(strb), .prot(prot), .other_error(other_error),
      .wait_cfg(wait_cfg), .ready(ready), .rdata(rdata),
      .slave_error(slave_error), .busy(busy), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One transfer from IDLE; returns at the negedge after the ready cycle.
   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [3:0] p, input logic [3:0] wc,
                       input int inj_at, output logic [31:0] rd, output logic er,
                       output int lat, output int busy_n);
      bit seen;
      seen   = 1'b0;
      lat    = 0;
      busy_n = 0;
      rd     = '0;
      er     = 1'b0;
      @(posedge clk); #1;
      sel = 1'b1; write = wr; addr = a; wdata = d; strb = s; prot = p; wait_cfg = wc;
      @(posedge clk); #1;
      sel = 1'b0; addr = 32'hFFFF_FFFC; wdata = 32'h0; wait_cfg = 4'hF;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         other_error = (k == inj_at);
         lat = k;
         if (busy) busy_n++;
         if (ready) begin
            seen = 1'b1;
            rd   = rdata;
            er   = slave_error;
            break;
         end
      end
      other_error = 1'b0;
      if (!seen) check("ready_timeout", 0, 1);
      @(negedge clk);
      check("idle_ready", {63'b0, ready}, 0);
      check("idle_rdata", rdata, 0);
      check("idle_err", {63'b0, slave_error}, 0);
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;
   int          bn;
   logic [3:0]  pulses;
   int          rdy_seen;

   initial begin
      rst = 1'b1; sel = 1'b0; addr = '0; write = 1'b0; wdata = '0; strb = '0;
      prot = '0; other_error = 1'b0; wait_cfg = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready", {63'b0, ready}, 0);
      check("rst_rdata", rdata, 0);
      check("rst_err", {63'b0, slave_error}, 0);
      check("rst_busy", {63'b0, busy}, 0);
      check("rst_cnt", {61'b0, err_count}, 0);

      // basic write/read with zero wait states
      xfer(1, 32'h40, 32'hDEADBEEF, 4'hF, 4'h2, 0, 0, rd, er, lat, bn);
      check("w40_lat", lat, 1);
      check("w40_err", {63'b0, er}, 0);
      xfer(0, 32'h40, 0, 4'h0, 4'h2, 0, 0, rd, er, lat, bn);
      check("r40_lat", lat, 1);
      check("r40_data", rd, 32'hDEADBEEF);
      check("r40_err", {63'b0, er}, 0);

      // byte strobes
      xfer(1, 32'h44, 32'h11223344, 4'hF, 4'h2, 0, 0, rd, er, lat, bn);
      xfer(1, 32'h44, 32'hAABBCCDD, 4'b0101, 4'h2, 0, 0, rd, er, lat, bn);
      xfer(0, 32'h44, 0, 4'h0, 4'h2, 0, 0, rd, er, lat, bn);
      check("strb_data", rd, 32'h11BB33DD);

      // wait states and injection
      xfer(0, 32'h44, 0, 4'h0, 4'h2, 3, 0, rd, er, lat, bn);
      check("wc3_lat", lat, 4);
      check("wc3_busy", bn, 4);
      check("wc3_data", rd, 32'h11BB33DD);
      xfer(0, 32'h44, 0, 4'h0, 4'h2, 3, 2, rd, er, lat, bn);
      check("inj_err", {63'b0, er}, 1);
      check("inj_rdata", rd, 0);
      check("inj_cnt", {61'b0, err_count}, 1);

      // decode errors; word 0 is where an out-of-range write would alias
      xfer(1, 32'h00, 32'hCAFEF00D, 4'hF, 4'h2, 0, 0, rd, er, lat, bn);
      xfer(1, 32'h400, 32'hFFFFFFFF, 4'hF, 4'h2, 0, 0, rd, er, lat, bn);
      check("oor_err", {63'b0, er}, 1);
      check("oor_cnt", {61'b0, err_count}, 2);
      xfer(0, 32'h42, 0, 4'h0, 4'h2, 0, 0, rd, er, lat, bn);
      check("mis_err", {63'b0, er}, 1);
      check("mis_rdata", rd, 0);
      check("mis_cnt", {61'b0, err_count}, 3);
      xfer(1, 32'h00, 32'h0, 4'hF, 4'h0, 0, 0, rd, er, lat, bn);
      check("priv_err", {63'b0, er}, 1);
      check("priv_cnt", {61'b0, err_count}, 4);
      xfer(0, 32'h00, 0, 4'h0, 4'h2, 0, 0, rd, er, lat, bn);
      check("w0_kept", rd, 32'hCAFEF00D);
      check("w0_err", {63'b0, er}, 0);
      xfer(0, 32'h40, 0, 4'h0, 4'h0, 0, 0, rd, er, lat, bn);
      check("unpriv16_data", rd, 32'hDEADBEEF);
      check("unpriv16_err", {63'b0, er}, 0);
      xfer(0, 32'h3C, 0, 4'h0, 4'h0, 0, 0, rd, er, lat, bn);
      check("priv15_err", {63'b0, er}, 1);
      check("priv15_cnt", {61'b0, err_count}, 5);

      // back-to-back writes with sel held
      @(posedge clk); #1;
      sel = 1'b1; write = 1'b1; addr = 32'h80; wdata = 32'h01020304; strb = 4'hF;
      prot = 4'h2; wait_cfg = 0;
      @(posedge clk); #1;
      addr = 32'h84; wdata = 32'h05060708;
      @(negedge clk); pulses[3] = ready;
      @(negedge clk); pulses[2] = ready;
      @(negedge clk); pulses[1] = ready;
      @(posedge clk); #1 sel = 1'b0;
      @(negedge clk); pulses[0] = ready;
      check("b2b_pulses", {60'b0, pulses}, 4'b1010);
      xfer(0, 32'h80, 0, 4'h0, 4'h2, 0, 0, rd, er, lat, bn);
      check("b2b_w1", rd, 32'h01020304);
      xfer(0, 32'h84, 0, 4'h0, 4'h2, 0, 0, rd, er, lat, bn);
      check("b2b_w2", rd, 32'h05060708);

      // strb=0 is a no-op write
      xfer(1, 32'h80, 32'hFFFFFFFF, 4'h0, 4'h2, 0, 0, rd, er, lat, bn);
      check("strb0_err", {63'b0, er}, 0);
      xfer(0, 32'h80, 0, 4'h0, 4'h2, 0, 0, rd, er, lat, bn);
      check("strb0_data", rd, 32'h01020304);

      // saturation of the 3-bit counter
      xfer(0, 32'h41, 0, 4'h0, 4'h2, 0, 0, rd, er, lat, bn);
      check("sat6", {61'b0, err_count}, 6);
      xfer(0, 32'h41, 0, 4'h0, 4'h2, 0, 0, rd, er, lat, bn);
      check("sat7", {61'b0, err_count}, 7);
      xfer(0, 32'h41, 0, 4'h0, 4'h2, 0, 0, rd, er, lat, bn);
      check("sat_hold_err", {63'b0, er}, 1);
      check("sat_hold", {61'b0, err_count}, 7);

      // reset in the middle of a waited write
      xfer(1, 32'h48, 32'h55AA55AA, 4'hF, 4'h2, 0, 0, rd, er, lat, bn);
      rdy_seen = 0;
      @(posedge clk); #1;
      sel = 1'b1; write = 1'b1; addr = 32'h48; wdata = 32'h12345678; strb = 4'hF;
      prot = 4'h2; wait_cfg = 5;
      @(posedge clk); #1 sel = 1'b0;
      @(negedge clk); if (ready) rdy_seen++;
      check("abort_busy_pre", {63'b0, busy}, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("abort_busy", {63'b0, busy}, 0);
      check("abort_cnt", {61'b0, err_count}, 0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (ready) rdy_seen++;
      end
      check("abort_no_ready", rdy_seen, 0);
      xfer(0, 32'h48, 0, 4'h0, 4'h2, 0, 0, rd, er, lat, bn);
      check("abort_kept", rd, 32'h55AA55AA);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/ahb_slave_mem_responder.md
Name: ahb_slave_mem_responder

Overview:
Parametrised, synthesisable memory-backed slave responder for the ahb_proto test environment. It replaces the fixed-width, behaviour-free slave interface with a real target. The block accepts sel/addr/write/wdata/strb/prot transfers and answers with a registered ready/rdata/slave_error handshake. It adds programmable wait states, byte-strobed writes, address/alignment/protection error checks, external error injection and a saturating error counter.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 32, data bus width; must be 8, 16, 32 or 64
DEPTH, 256, memory depth in DATA_WIDTH words; power of two
BASE_ADDR, 0, byte address of word 0
PRIV_WORDS, 16, words [0, PRIV_WORDS) require privileged access (prot[1]=1)
WAIT_W, 4, width of wait_cfg
CNT_W, 16, width of err_count

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
sel  in  1  transfer request; held with payload until ready sampled high
addr  in  ADDR_WIDTH  byte address
write  in  1  1=write, 0=read
wdata  in  DATA_WIDTH  write data
strb  in  DATA_WIDTH/8  byte write enables
prot  in  4  protection attributes; bit1 = privileged
other_error  in  1  error injection; sampled during any non-IDLE cycle
wait_cfg  in  WAIT_W  wait states per transfer; sampled at acceptance
ready  out  1  transfer complete, one-cycle pulse
rdata  out  DATA_WIDTH  read data, valid while ready=1
slave_error  out  1  error response, valid while ready=1
busy  out  1  high in WAIT or RESP
err_count  out  CNT_W  saturating count of error responses

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; ready=0, rdata=0, slave_error=0, busy=0, err_count=0; wait counter=0; inject flag=0. Memory contents are not reset. Reset mid-transfer aborts it: no write commits and no ready is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE, sel=1: latch addr, write, wdata, strb, prot; cnt<=wait_cfg; inj<=other_error. Next state: WAIT if wait_cfg!=0, else RESP.
- WAIT: cnt decrements each cycle; inj|=other_error. Go to RESP when cnt==1.
- RESP: ready=1 for exactly one cycle; inj|=other_error is evaluated this cycle. Next state is IDLE.
- Latency: ready is high wait_cfg+1 cycles after the accepting edge. wait_cfg=0 gives ready in the cycle after acceptance.
- In IDLE, sel=1 in the cycle after RESP is a new transfer (back-to-back allowed). Minimum period is wait_cfg+2 cycles.
- Changes on sel or payload after acceptance are ignored; latched values are used.
- Decode: off = addr - BASE_ADDR (unsigned, ADDR_WIDTH bits); index = off >> log2(DATA_WIDTH/8).
- Error sources, any of:
  - inj (other_error);
  - off >= DEPTH*DATA_WIDTH/8 (also covers addr < BASE_ADDR via wrap);
  - off not aligned to DATA_WIDTH/8;
  - index < PRIV_WORDS and prot[1]=0.
- Error response: slave_error=1 with ready; rdata=0; write suppressed entirely; err_count+1, saturating at all-ones (no wrap).
- Good write: memory byte i updated iff strb[i]=1, at the RESP edge. strb=0 is a legal no-op.
- Good read: rdata = mem[index] as of the RESP cycle, including writes committed by earlier transfers.
- rdata and slave_error are 0 whenever ready=0.
- busy = (state != IDLE).
- wait_cfg changes mid-transfer take effect at the next acceptance only.

Test Plan:
- After reset, write 0xDEADBEEF to addr BASE+0x40 with strb=0xF, prot=0x2, wait_cfg=0. Then read the same address → ready 1 cycle after acceptance, rdata=0xDEADBEEF, slave_error=0.
- Write 0x11223344 to 0x44, then write 0xAABBCCDD with strb=0b0101, then read → rdata=0x11BB33DD.
- wait_cfg=3, read 0x44 → ready exactly 4 cycles after acceptance, busy high for 4 cycles. Assert other_error for one cycle during WAIT → slave_error=1, rdata=0, err_count=1.
- Error cases, each → slave_error=1, memory unchanged, err_count increments:
  - write to addr 0x400 (DEPTH=256);
  - read from addr 0x42 (misaligned);
  - write to 0x00 with prot=0x0 (unprivileged access to a privileged word).
- Back-to-back: sel held high across two writes, wait_cfg=0 → ready pulses 2 cycles apart, both writes committed. Force err_count to all-ones, then an error → err_count stays all-ones.
- Assert rst during WAIT of a write → ready never asserts, target word keeps its old value, state is IDLE next cycle, err_count=0.
